// File: rtl/axi4_lite_slave_regs.sv
// -----------------------------------------------------------------------------
// axi4_lite_slave_regs
//
// Purpose
//   AXI4-Lite subordinate that is the target for a bank of NUM_REGS read/write
//   registers. It answers the write and read transactions issued by an
//   AXI4-Lite manager and gives user logic the register contents plus a
//   one-cycle pulse for every register that has been written.
//
// Parameters
//   DATA_BYTES  data bus width in bytes (wdata/rdata = DATA_BYTES*8 bits)
//   ADDR_BYTES  address bus width in bytes (awaddr/araddr = ADDR_BYTES*8 bits)
//   NUM_REGS    number of registers, word index = addr >> log2(DATA_BYTES);
//               must be <= 2**(ADDR_BYTES*8)/DATA_BYTES
//
// Ports
//   aclk, areset                 clock (rising edge) and synchronous active-high reset
//   awvalid/awready/awaddr/awprot  write address channel (awprot ignored)
//   wvalid/wready/wdata/wstrb    write data channel, wstrb = byte enables
//   bvalid/bready/bresp          write response channel
//   arvalid/arready/araddr/arprot  read address channel (arprot ignored)
//   rvalid/rready/rdata/rresp    read data channel
//   regs_o                       flat register contents, reg i at [i*W +: W]
//   wr_pulse_o                   bit i high for one cycle after register i is written
//
// Build option
//   AXI4_LITE_REGS_SLVERR_EN  when defined, accesses to an index >= NUM_REGS
//   answer SLVERR (2'b10); otherwise they answer OKAY. Data behaviour is the
//   same in both builds: such writes are dropped and such reads return 0.
// -----------------------------------------------------------------------------
module axi4_lite_slave_regs #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_BYTES = 1,
  parameter int NUM_REGS   = 16
) (
  input  logic                               aclk,
  input  logic                               areset,
  // write address channel
  input  logic                               awvalid,
  output logic                               awready,
  input  logic [ADDR_BYTES*8-1:0]            awaddr,
  input  logic [2:0]                         awprot,
  // write data channel
  input  logic                               wvalid,
  output logic                               wready,
  input  logic [DATA_BYTES*8-1:0]            wdata,
  input  logic [DATA_BYTES-1:0]              wstrb,
  // write response channel
  output logic                               bvalid,
  input  logic                               bready,
  output logic [1:0]                         bresp,
  // read address channel
  input  logic                               arvalid,
  output logic                               arready,
  input  logic [ADDR_BYTES*8-1:0]            araddr,
  input  logic [2:0]                         arprot,
  // read data channel
  output logic                               rvalid,
  input  logic                               rready,
  output logic [DATA_BYTES*8-1:0]            rdata,
  output logic [1:0]                         rresp,
  // user-side register view
  output logic [NUM_REGS*DATA_BYTES*8-1:0]   regs_o,
  output logic [NUM_REGS-1:0]                wr_pulse_o
);

  localparam int DW    = DATA_BYTES * 8;
  localparam int AW_W  = ADDR_BYTES * 8;
  localparam int LSB   = $clog2(DATA_BYTES);
  localparam int IDX_W = AW_W - LSB;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4_LITE_REGS_SLVERR_EN
  localparam logic [1:0] RESP_MISS = 2'b10;
`else
  localparam logic [1:0] RESP_MISS = 2'b00;
`endif

  // Replace the strobed byte lanes of old_word with those of new_word.
  function automatic logic [DW-1:0] merge_lanes(
    input logic [DW-1:0]         old_word,
    input logic [DW-1:0]         new_word,
    input logic [DATA_BYTES-1:0] strb
  );
    logic [DW-1:0] res;
    res = old_word;
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (strb[b]) begin
        res[b*8 +: 8] = new_word[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_word[b*8 +: 8];
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DW-1:0]         regs_r [NUM_REGS];

  logic                  aw_held_r;
  logic [IDX_W-1:0]      aw_idx_r;
  logic                  w_held_r;
  logic [DW-1:0]         w_data_r;
  logic [DATA_BYTES-1:0] w_strb_r;

  logic                  bvalid_r;
  logic [1:0]            bresp_r;
  logic [NUM_REGS-1:0]   wr_pulse_r;

  logic                  rvalid_r;
  logic [DW-1:0]         rdata_r;
  logic [1:0]            rresp_r;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic                  aw_hs_s;
  logic                  w_hs_s;
  logic                  ar_hs_s;
  logic                  commit_s;
  logic [IDX_W-1:0]      aw_idx_in_s;
  logic [IDX_W-1:0]      ar_idx_s;
  logic [IDX_W-1:0]      wr_idx_s;
  logic [DW-1:0]         wr_data_s;
  logic [DATA_BYTES-1:0] wr_strb_s;
  logic [NUM_REGS-1:0]   wr_sel_s;
  logic                  rd_hit_s;
  logic [DW-1:0]         rd_word_s;
  logic                  unused_s;

  // Readies depend only on internal state (and reset), never on the valids.
  assign awready = !areset && !aw_held_r && !bvalid_r;
  assign wready  = !areset && !w_held_r  && !bvalid_r;
  assign arready = !areset && !rvalid_r;

  assign aw_hs_s = awvalid && awready;
  assign w_hs_s  = wvalid  && wready;
  assign ar_hs_s = arvalid && arready;

  // Low address bits select a byte inside the word and are ignored.
  assign aw_idx_in_s = awaddr[AW_W-1:LSB];
  assign ar_idx_s    = araddr[AW_W-1:LSB];

  // Protection bits and the byte-offset address bits carry no meaning here.
  assign unused_s = ^{awprot, arprot, awaddr, araddr};

  // Pick address/data from the capture registers or straight from the bus, and decide whether this edge commits the write.
  always_comb begin
    wr_idx_s  = aw_held_r ? aw_idx_r : aw_idx_in_s;
    wr_data_s = w_held_r  ? w_data_r : wdata;
    wr_strb_s = w_held_r  ? w_strb_r : wstrb;
    // A commit needs both halves, at least one of which arrives this cycle.
    commit_s  = (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s);
  end

  // One-hot write select and read mux; an index with no matching register leaves both empty.
  always_comb begin
    wr_sel_s  = '0;
    rd_hit_s  = 1'b0;
    rd_word_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel_s[i] = commit_s && (wr_idx_s == IDX_W'(i));
      rd_hit_s    = rd_hit_s | (ar_idx_s == IDX_W'(i));
      rd_word_s   = rd_word_s | ({DW{ar_idx_s == IDX_W'(i)}} & regs_r[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Write channel: capture AW/W halves, raise the response and the write pulse on commit.
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_held_r  <= 1'b0;
      aw_idx_r   <= '0;
      w_held_r   <= 1'b0;
      w_data_r   <= '0;
      w_strb_r   <= '0;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
      wr_pulse_r <= '0;
    end else begin
      wr_pulse_r <= wr_sel_s;
      if (commit_s) begin
        // bvalid is low whenever a handshake can happen, so no pending response is overwritten.
        aw_held_r <= 1'b0;
        w_held_r  <= 1'b0;
        bvalid_r  <= 1'b1;
        bresp_r   <= (|wr_sel_s) ? RESP_OKAY : RESP_MISS;
      end else begin
        if (aw_hs_s) begin
          aw_held_r <= 1'b1;
          aw_idx_r  <= aw_idx_in_s;
        end
        if (w_hs_s) begin
          w_held_r <= 1'b1;
          w_data_r <= wdata;
          w_strb_r <= wstrb;
        end
        if (bvalid_r && bready) begin
          bvalid_r <= 1'b0;
        end
      end
    end
  end

  // Register array: strobed byte lanes of the selected register take the write data.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel_s[i]) begin
          regs_r[i] <= merge_lanes(regs_r[i], wr_data_s, wr_strb_s);
        end
      end
    end
  end

  // Read channel: sample the array on the AR handshake (pre-write value on a same-edge write) and hold until rready.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
      rresp_r  <= RESP_OKAY;
    end else begin
      if (ar_hs_s) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_word_s;
        rresp_r  <= rd_hit_s ? RESP_OKAY : RESP_MISS;
      end else if (rvalid_r && rready) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bvalid     = bvalid_r;
  assign bresp      = bresp_r;
  assign rvalid     = rvalid_r;
  assign rdata      = rdata_r;
  assign rresp      = rresp_r;
  assign wr_pulse_o = wr_pulse_r;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
    assign regs_o[gi*DW +: DW] = regs_r[gi];
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_slave_regs
//
// Self-checking bench for axi4_lite_slave_regs (DATA_BYTES=4, ADDR_BYTES=1,
// NUM_REGS=16). A stimulus process drives the bus once per cycle and runs a
// transaction-level reference model: a register array, pending AW/W halves
// and outstanding response flags. Expected write/read responses are pushed
// into queues; a monitor on the falling edge pops and compares them whenever
// the DUT presents bvalid/rvalid, and also compares readies, regs_o and
// wr_pulse_o against the model. Honours AXI4_LITE_REGS_SLVERR_EN.
// -----------------------------------------------------------------------------
module tb_axi4_lite_slave_regs;

  localparam int DATA_BYTES = 4;
  localparam int ADDR_BYTES = 1;
  localparam int NUM_REGS   = 16;

`ifdef AXI4_LITE_REGS_SLVERR_EN
  localparam logic [1:0] MISS_RESP = 2'b10;
`else
  localparam logic [1:0] MISS_RESP = 2'b00;
`endif

  logic         aclk;
  logic         areset;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [7:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [511:0] regs_o;
  logic [15:0]  wr_pulse_o;

  axi4_lite_slave_regs #(
    .DATA_BYTES(DATA_BYTES), .ADDR_BYTES(ADDR_BYTES), .NUM_REGS(NUM_REGS)
  ) dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;
  bit run_mon = 1'b0;

  // reference model
  logic [31:0] m_regs [NUM_REGS];
  logic [15:0] m_pulse;
  bit          aw_pend, w_pend, b_out, r_out;
  logic [7:0]  m_awaddr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;

  // scoreboard queues
  logic [1:0]  bq[$];
  logic [31:0] rdq[$];
  logic [1:0]  rrq[$];

  // expectations for the current cycle, consumed by the monitor
  logic         exp_awready, exp_wready, exp_arready, exp_bvalid, exp_rvalid;
  logic [511:0] exp_regs;
  logic [15:0]  exp_pulse;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Publish the model's view of this cycle, advance the model across the next edge, then wait for it.
  task automatic tick();
    bit   rst_now, aw_f, w_f, ar_f;
    int   idx;
    rst_now     = areset;
    exp_awready = !areset && !aw_pend && !b_out;
    exp_wready  = !areset && !w_pend  && !b_out;
    exp_arready = !areset && !r_out;
    exp_bvalid  = b_out;
    exp_rvalid  = r_out;
    exp_pulse   = m_pulse;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i*32 +: 32] = m_regs[i];
    if (rst_now) begin
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 32'h0;
      m_pulse = 16'h0; aw_pend = 1'b0; w_pend = 1'b0; b_out = 1'b0; r_out = 1'b0;
    end else begin
      aw_f = awvalid && exp_awready;
      w_f  = wvalid  && exp_wready;
      ar_f = arvalid && exp_arready;
      // read side sees the array as it was before this edge
      if (r_out && rready) r_out = 1'b0;
      if (ar_f) begin
        idx = int'(araddr) / 4;
        r_out = 1'b1;
        rdq.push_back((idx < NUM_REGS) ? m_regs[idx] : 32'h0);
        rrq.push_back((idx < NUM_REGS) ? 2'b00 : MISS_RESP);
      end
      m_pulse = 16'h0;
      if (b_out && bready) b_out = 1'b0;
      if (aw_f) begin aw_pend = 1'b1; m_awaddr = awaddr; end
      if (w_f)  begin w_pend = 1'b1; m_wdata = wdata; m_wstrb = wstrb; end
      if (aw_pend && w_pend) begin
        idx = int'(m_awaddr) / 4;
        if (idx < NUM_REGS) begin
          for (int b = 0; b < 4; b++)
            if (m_wstrb[b]) m_regs[idx][b*8 +: 8] = m_wdata[b*8 +: 8];
          m_pulse[idx] = 1'b1;
          bq.push_back(2'b00);
        end else begin
          bq.push_back(MISS_RESP);
        end
        b_out = 1'b1; aw_pend = 1'b0; w_pend = 1'b0;
      end
    end
    @(posedge aclk);
    #1;
    if (rst_now) begin
      bq.delete(); rdq.delete(); rrq.delete();
    end
  endtask

  task automatic idle();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
  endtask

  task automatic drive_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
  endtask

  task automatic drive_rd(input logic [7:0] a);
    arvalid = 1'b1; araddr = a;
  endtask

  // Monitor: compare every visible output against the model, pop responses as they are taken.
  always @(negedge aclk) begin
    if (run_mon) begin
      chk("awready", awready, exp_awready);
      chk("wready", wready, exp_wready);
      chk("arready", arready, exp_arready);
      chk("bvalid", bvalid, exp_bvalid);
      chk("rvalid", rvalid, exp_rvalid);
      chk("regs_o", regs_o, exp_regs);
      chk("wr_pulse_o", wr_pulse_o, exp_pulse);
      if (bvalid === 1'b1) begin
        if (bq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL bq_empty: got bvalid=1 expected no response pending");
        end else begin
          chk("bresp", bresp, bq[0]);
          if (bready) void'(bq.pop_front());
        end
      end
      if (rvalid === 1'b1) begin
        if (rdq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rq_empty: got rvalid=1 expected no response pending");
        end else begin
          chk("rdata", rdata, rdq[0]);
          chk("rresp", rresp, rrq[0]);
          if (rready) begin
            void'(rdq.pop_front());
            void'(rrq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 32'h0;
    m_pulse = 16'h0; aw_pend = 1'b0; w_pend = 1'b0; b_out = 1'b0; r_out = 1'b0;
    m_awaddr = 8'h0; m_wdata = 32'h0; m_wstrb = 4'h0;
    awprot = 3'b000; arprot = 3'b000;
    awaddr = 8'h0; araddr = 8'h0; wdata = 32'h0; wstrb = 4'h0;
    areset = 1'b1;
    idle();
    @(posedge aclk); #1;

    // reset
    tick();
    run_mon = 1'b1;
    tick();
    areset = 1'b0;
    #1;
    chk("rst_release_awready", awready, 1'b1);
    chk("rst_release_arready", arready, 1'b1);
    tick();

    // AW+W same cycle -> bvalid next cycle, pulse on reg 1 for one cycle
    drive_wr(8'h04, 32'hDEADBEEF, 4'hF);
    tick();
    idle();
    chk("min_latency_bvalid", bvalid, 1'b1);
    chk("reg1_value", regs_o[32 +: 32], 32'hDEADBEEF);
    chk("pulse_reg1", wr_pulse_o, 16'h0002);
    tick();
    chk("pulse_one_cycle", wr_pulse_o, 16'h0000);
    drive_rd(8'h04);
    tick();
    idle();
    chk("read_reg1", rdata, 32'hDEADBEEF);
    tick();

    // W three cycles before AW, then a partial-strobe write
    wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF;
    tick();
    idle();
    tick(); tick(); tick();
    awvalid = 1'b1; awaddr = 8'h08;
    tick();
    idle();
    tick();
    drive_wr(8'h08, 32'hFFFFFFFF, 4'h3);
    tick();
    idle();
    tick();
    chk("strobe_merge", regs_o[64 +: 32], 32'h1234FFFF);
    drive_rd(8'h08);
    tick();
    idle();
    tick();

    // response back-pressure on both channels
    drive_wr(8'h0C, 32'hA5A5A5A5, 4'hF);
    bready = 1'b0;
    tick();
    repeat (5) tick();
    idle();
    tick();
    drive_rd(8'h0C);
    rready = 1'b0;
    tick();
    arvalid = 1'b0;
    repeat (5) tick();
    rready = 1'b1;
    tick();

    // out-of-range index 49
    drive_wr(8'hC4, 32'h55AA55AA, 4'hF);
    tick();
    idle();
    chk("oor_bresp", bresp, MISS_RESP);
    tick();
    drive_rd(8'hC4);
    tick();
    idle();
    chk("oor_rdata", rdata, 32'h0);
    tick();

    // same-edge read and write of register 1
    drive_wr(8'h04, 32'hCAFEF00D, 4'hF);
    drive_rd(8'h04);
    tick();
    idle();
    chk("same_edge_old", rdata, 32'hDEADBEEF);
    tick();
    drive_rd(8'h04);
    tick();
    idle();
    chk("same_edge_new", rdata, 32'hCAFEF00D);
    tick();

    // reset with both responses pending
    drive_wr(8'h10, 32'h11112222, 4'hF);
    drive_rd(8'h00);
    bready = 1'b0; rready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    bready = 1'b1; rready = 1'b1;
    #1;
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_regs", regs_o, 512'h0);
    chk("rst_wready", wready, 1'b1);
    tick();

    // randomized traffic
    repeat (1500) begin
      areset  = ($urandom_range(0, 299) == 0);
      awvalid = $urandom_range(0, 1);
      wvalid  = $urandom_range(0, 1);
      arvalid = $urandom_range(0, 1);
      awaddr  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 63));
      araddr  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 63));
      wdata   = $urandom;
      wstrb   = 4'($urandom_range(0, 15));
      bready  = ($urandom_range(0, 9) < 7);
      rready  = ($urandom_range(0, 9) < 7);
      tick();
    end

    // drain
    areset = 1'b0;
    idle();
    repeat (4) tick();
    chk("bq_drained", 512'(bq.size()), 512'h0);
    chk("rq_drained", 512'(rdq.size()), 512'h0);

    run_mon = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
